decode_issue_ctrl: RTL and testbench
====================================

// Module: decode_issue_ctrl
// PURPOSE
//  Issue/stall controller for the ID stage: decides each cycle whether the decoded instruction may advance to EX.
//  Keeps a 32-entry register scoreboard of in-flight writes, stalls on RAW/WAW hazards and on I-cache miss.
//  Inserts a fixed-length bubble window after a branch flush.
//  Sits beside the decode stage; drives the IF/ID hold, the PC hold and the ID/EX valid bit.
// PARAMETERS
//  FLUSH_CYCLES  2   bubbles injected after flush_req (1..15)
//  CNT_W         16  width of the saturating stall-cycle counter
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous, active-high reset
//  id_valid     in   1      ID holds a real instruction
//  id_hit       in   1      fetch of the ID instruction hit the I-cache (HIT)
//  id_rs        in   5      source reg 1 (INSTRUCTION[25:21])
//  id_rt        in   5      source reg 2 (INSTRUCTION[20:16])
//  id_uses_rt   in   1      rt is read as a source (R-type, store, branch)
//  id_reg_write in   1      control-unit RegWrite
//  id_dest      in   5      destination after RegDst mux
//  wb_valid     in   1      WB stage commits a register write this cycle
//  wb_reg       in   5      register written by WB
//  flush_req    in   1      branch taken in EX: squash younger instructions
//  issue        out  1      ID instruction advances to EX this cycle (ID/EX valid)
//  if_id_hold   out  1      hold IF/ID register and PC
//  busy_mask    out  32     scoreboard, bit n = write to reg n pending
//  stall_cnt    out  CNT_W  cycles with id_valid=1 and issue=0, saturating
// BEHAVIOUR
//  Reset: state=RUN, busy_mask=0, flush counter=0, stall_cnt=0; issue=0, if_id_hold=0.
//  FSM (registered), outputs combinational from state+inputs:
//   RUN:   hazard = busy[id_rs] | (id_uses_rt & busy[id_rt]) | (id_reg_write & busy[id_dest]).
//          Reg 0 never hazards, never set.
//          issue = id_valid & id_hit & ~hazard & ~flush_req.
//          if_id_hold = id_valid & ~issue & ~flush_req.
//          id_valid & ~id_hit & ~flush_req -> MISS.
//   MISS:  issue=0, if_id_hold=1; id_hit=1 -> RUN; the instruction re-evaluates in RUN next cycle.
//   FLUSH: issue=0, if_id_hold=0 (fetch refills); counter counts down from FLUSH_CYCLES-1.
//          At 0 -> RUN.
//  flush_req has top priority in every state: issue=0 that cycle.
//   Enter FLUSH and load the counter; a flush during FLUSH reloads the counter.
//  Scoreboard update, per cycle: clear bit wb_reg if wb_valid; set bit id_dest if issue & id_reg_write & id_dest!=0.
//   Set and clear on the same reg in one cycle: set wins (WAW stall makes this newer-write only).
//  No WB bypass: a source cleared by WB this cycle is still seen busy; issue occurs one cycle later.
//  wb_valid to a non-busy reg: no effect, no error.
//  Flush does not clear busy_mask; squashed instructions never issued, so never set bits.
//  Latency: hazard-free hit issues in the same cycle id_valid rises (0-cycle).
//   Minimum RAW stall = cycles until WB + 1.
//  stall_cnt increments when id_valid & ~issue (any state), holds at 2^CNT_W-1.
//  rst mid-operation: all state returns to reset values immediately (asynchronous); no partial issue.
// STRUCTURE
//  Shared package: state encodings ST_RUN=2'd0, ST_MISS=2'd1, ST_FLUSH=2'd2; REG_ZERO=5'd0.
//  Sub-module reg_scoreboard (32-bit busy_mask, set/clear ports, 3 read ports) instanced once.
//  FSM, flush counter and stall counter in the top level.
// TESTING
//  Reset: rst=1 mid-run with busy_mask!=0 -> busy_mask=0, issue=0, stall_cnt=0 without clock edge.
//  RAW: issue add r3 (dest 3); next ID reads rs=3 -> issue=0, if_id_hold=1.
//   wb_valid, wb_reg=3 -> issue one cycle after WB cycle.
//  Reg zero: dest=0 issued, then rs=0 read -> no stall, busy_mask stays 0.
//  Miss: id_valid=1, id_hit=0 for 3 cycles -> MISS, issue=0, stall_cnt +3.
//   id_hit=1 -> RUN, issue next cycle.
//  Flush: flush_req during RAW stall -> issue=0 for FLUSH_CYCLES=2 cycles, if_id_hold=0.
//   busy_mask unchanged; flush repeated in FLUSH restarts 2-cycle window.
//  Same-cycle: wb_reg=5 clear while issuing dest 5 -> bit 5 remains set.
//   stall_cnt with CNT_W=4 saturates at 15.

Source files
------------

// File: rtl/decode_issue_ctrl_pkg.sv
// Shared definitions for the ID-stage issue/stall controller and its register scoreboard.
package decode_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MISS  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/decode_issue_ctrl_reg_scoreboard.sv
// 32-entry in-flight register-write scoreboard with one set port, one clear port and three read ports.
module reg_scoreboard
  import decode_issue_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        set_en,
  input  logic [4:0]  set_reg,
  input  logic        clr_en,
  input  logic [4:0]  clr_reg,
  input  logic [4:0]  rd_a,
  input  logic [4:0]  rd_b,
  input  logic [4:0]  rd_c,
  output logic [31:0] busy_mask,
  output logic        busy_a,
  output logic        busy_b,
  output logic        busy_c
);

  logic [31:0] r_busy;
  logic [31:0] w_busy_nxt;

  // Set is applied after clear so a same-cycle set on the cleared register survives.
  always_comb begin
    w_busy_nxt = r_busy;
    if (clr_en) w_busy_nxt[clr_reg] = 1'b0;
    if (set_en && (set_reg != REG_ZERO)) w_busy_nxt[set_reg] = 1'b1;
    w_busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  assign busy_mask = r_busy;
  assign busy_a    = r_busy[rd_a];
  assign busy_b    = r_busy[rd_b];
  assign busy_c    = r_busy[rd_c];

endmodule

// File: rtl/decode_issue_ctrl.sv
// ID-stage issue/stall controller: scoreboard hazards, I-cache miss hold and post-flush bubble window.
module decode_issue_ctrl
  import decode_issue_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_hit,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_reg_write,
  input  logic [4:0]       id_dest,
  input  logic             wb_valid,
  input  logic [4:0]       wb_reg,
  input  logic             flush_req,
  output logic             issue,
  output logic             if_id_hold,
  output logic [31:0]      busy_mask,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_flush_cnt, w_flush_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_busy_rs, w_busy_rt, w_busy_dest;
  logic             w_hazard, w_issue, w_hold;

  reg_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (issue & id_reg_write),
    .set_reg   (id_dest),
    .clr_en    (wb_valid),
    .clr_reg   (wb_reg),
    .rd_a      (id_rs),
    .rd_b      (id_rt),
    .rd_c      (id_dest),
    .busy_mask (busy_mask),
    .busy_a    (w_busy_rs),
    .busy_b    (w_busy_rt),
    .busy_c    (w_busy_dest)
  );

  assign w_hazard = w_busy_rs | (id_uses_rt & w_busy_rt) | (id_reg_write & w_busy_dest);

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_issue         = 1'b0;
    w_hold          = 1'b0;
    if (flush_req) begin
      w_state_nxt     = ST_FLUSH;
      w_flush_cnt_nxt = FLUSH_LOAD;
    end else begin
      case (r_state)
        ST_RUN: begin
          w_issue = id_valid & id_hit & ~w_hazard;
          w_hold  = id_valid & ~w_issue;
          if (id_valid && !id_hit) w_state_nxt = ST_MISS;
        end
        ST_MISS: begin
          w_hold = 1'b1;
          if (id_hit) w_state_nxt = ST_RUN;
        end
        ST_FLUSH: begin
          // Fetch refills during the bubble window, so IF/ID is not held.
          if (r_flush_cnt == 4'd0) w_state_nxt = ST_RUN;
          else                     w_flush_cnt_nxt = r_flush_cnt - 4'd1;
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  // Reset gates the combinational outputs so nothing issues while rst is high.
  assign issue      = w_issue & ~rst;
  assign if_id_hold = w_hold & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 4'd0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      if (id_valid && !issue && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed, table-driven bench for decode_issue_ctrl with hand-written reset and saturation sequences.
module tb_decode_issue_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_hit, id_uses_rt, id_reg_write, wb_valid, flush_req;
  logic [4:0]       id_rs, id_rt, id_dest, wb_reg;
  logic             issue, if_id_hold;
  logic [31:0]      busy_mask;
  logic [CNT_W-1:0] stall_cnt;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        va, hi;
    logic [4:0]  rs, rt;
    logic        ur, rw;
    logic [4:0]  de;
    logic        wv;
    logic [4:0]  wr;
    logic        fl;
    logic        ei, eh;
    logic [31:0] eb;
    logic [3:0]  es;
  } vec_t;

  vec_t vq[$];

  decode_issue_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_hit       (id_hit),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_reg_write (id_reg_write),
    .id_dest      (id_dest),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .flush_req    (flush_req),
    .issue        (issue),
    .if_id_hold   (if_id_hold),
    .busy_mask    (busy_mask),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int va, int hi, int rs, int rt, int ur, int rw, int de,
                              int wv, int wr, int fl, int ei, int eh, int eb, int es);
    vec_t v;
    v.va = va[0]; v.hi = hi[0]; v.rs = rs[4:0]; v.rt = rt[4:0];
    v.ur = ur[0]; v.rw = rw[0]; v.de = de[4:0]; v.wv = wv[0];
    v.wr = wr[4:0]; v.fl = fl[0]; v.ei = ei[0]; v.eh = eh[0];
    v.eb = eb; v.es = es[3:0];
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.va; id_hit = v.hi; id_rs = v.rs; id_rt = v.rt;
    id_uses_rt = v.ur; id_reg_write = v.rw; id_dest = v.de;
    wb_valid = v.wv; wb_reg = v.wr; flush_req = v.fl;
  endtask

  task automatic check_vec(input vec_t v, input int idx);
    check("issue", idx, {31'd0, issue}, {31'd0, v.ei});
    check("if_id_hold", idx, {31'd0, if_id_hold}, {31'd0, v.eh});
    check("busy_mask", idx, busy_mask, v.eb);
    check("stall_cnt", idx, {28'd0, stall_cnt}, {28'd0, v.es});
  endtask

  initial begin
    vec_t v;
    //          va hi rs rt ur rw de wv wr fl  ei eh busy    stall
    vq.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 0,0,0,      0));  // idle
    vq.push_back(mk(1,1,1,2,1,1,3, 0,0,0, 1,0,0,      0));  // add r3 issues
    vq.push_back(mk(1,1,3,0,0,1,4, 0,0,0, 0,1,'h8,    0));  // RAW on r3
    vq.push_back(mk(1,1,3,0,0,1,4, 1,3,0, 0,1,'h8,    1));  // WB r3, no bypass
    vq.push_back(mk(1,1,3,0,0,1,4, 0,0,0, 1,0,0,      2));  // issues after WB
    vq.push_back(mk(1,1,0,0,1,1,0, 1,4,0, 1,0,'h10,   2));  // dest r0
    vq.push_back(mk(1,1,0,0,1,0,0, 1,7,0, 1,0,0,      2));  // read r0, WB non-busy
    vq.push_back(mk(1,0,1,1,0,0,0, 0,0,0, 0,1,0,      2));  // miss 1
    vq.push_back(mk(1,0,1,1,0,0,0, 0,0,0, 0,1,0,      3));  // miss 2
    vq.push_back(mk(1,0,1,1,0,0,0, 0,0,0, 0,1,0,      4));  // miss 3
    vq.push_back(mk(1,1,1,1,0,0,0, 0,0,0, 0,1,0,      5));  // hit in MISS
    vq.push_back(mk(1,1,1,1,0,0,0, 0,0,0, 1,0,0,      6));  // issues in RUN
    vq.push_back(mk(1,1,1,0,0,1,6, 0,0,0, 1,0,0,      6));  // write r6
    vq.push_back(mk(1,1,6,0,0,0,0, 0,0,0, 0,1,'h40,   6));  // RAW on r6
    vq.push_back(mk(1,1,6,0,0,0,0, 0,0,1, 0,0,'h40,   7));  // flush in stall
    vq.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 0,0,'h40,   8));  // bubble 1
    vq.push_back(mk(1,1,6,0,0,0,0, 0,0,0, 0,0,'h40,   8));  // bubble 2
    vq.push_back(mk(1,1,6,0,0,0,0, 0,0,0, 0,1,'h40,   9));  // RUN, r6 still busy
    vq.push_back(mk(0,0,0,0,0,0,0, 0,0,1, 0,0,'h40,  10));  // flush
    vq.push_back(mk(0,0,0,0,0,0,0, 0,0,1, 0,0,'h40,  10));  // flush again
    vq.push_back(mk(1,1,1,0,0,0,0, 0,0,0, 0,0,'h40,  10));  // restarted window 1
    vq.push_back(mk(1,1,1,0,0,0,0, 0,0,0, 0,0,'h40,  11));  // restarted window 2
    vq.push_back(mk(1,1,1,0,0,0,0, 1,6,0, 1,0,'h40,  12));  // RUN issues
    vq.push_back(mk(1,1,1,0,0,1,5, 1,5,0, 1,0,0,     12));  // set/clear r5 same cycle
    vq.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 0,0,'h20,  12));  // r5 remains set
    vq.push_back(mk(1,1,1,0,0,1,5, 0,0,0, 0,1,'h20,  12));  // WAW on r5
    vq.push_back(mk(0,0,0,0,0,0,0, 1,5,0, 0,0,'h20,  13));  // WB r5
    vq.push_back(mk(1,1,1,0,0,1,8, 0,0,0, 1,0,0,     13));  // write r8
    vq.push_back(mk(1,1,1,8,0,0,0, 0,0,0, 1,0,'h100, 13));  // rt unused
    vq.push_back(mk(1,1,1,8,1,0,0, 0,0,0, 0,1,'h100, 13));  // rt used -> RAW
    vq.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 0,0,'h100, 14));  // idle

    rst = 1'b1;
    drive(vq[0]);
    #2;
    check("reset_busy", -1, busy_mask, 32'd0);
    check("reset_stall", -1, {28'd0, stall_cnt}, 32'd0);
    check("reset_issue", -1, {31'd0, issue}, 32'd0);
    check("reset_hold", -1, {31'd0, if_id_hold}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vq[i]);
      @(negedge clk);
      check_vec(vq[i], i);
    end

    // Saturation: stall_cnt sits at 14; three more miss cycles must stop at 15.
    v = mk(1,0,1,0,0,0,0, 0,0,0, 0,1,'h100, 14);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      drive(v);
      @(negedge clk);
      check_vec(v, 100 + k);
      v.es = 4'd15;
    end

    // Asynchronous reset between edges while busy_mask is non-zero and an issuable instruction is present.
    drive(mk(1,1,1,0,0,1,2, 0,0,0, 0,0,0, 0));
    #2;
    rst = 1'b1;
    #1;
    check("async_busy", 200, busy_mask, 32'd0);
    check("async_stall", 200, {28'd0, stall_cnt}, 32'd0);
    check("async_issue", 200, {31'd0, issue}, 32'd0);
    check("async_hold", 200, {31'd0, if_id_hold}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_reset_issue", 201, {31'd0, issue}, 32'd1);
    @(negedge clk);
    check("post_reset_busy", 202, busy_mask, 32'h4);
    check("post_reset_waw", 202, {31'd0, issue}, 32'd0);
    check("post_reset_hold", 202, {31'd0, if_id_hold}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
